// File: rtl/reg_seq_pkg.sv
// Shared opcodes, FSM encoding and default sizes for the register-file ALU sequencer.
package reg_seq_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AW_DEF    = 3;
  localparam int OP_W      = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_LDI  = 3'd5;
  localparam logic [OP_W-1:0] OP_MOV  = 3'd6;
  localparam logic [OP_W-1:0] OP_ADDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_WR   = 2'd3
  } seq_state_e;

  // Ops ADD..XOR are the only ones that fetch a second register operand.
  function automatic logic op_reads_b(input logic [OP_W-1:0] op);
    return (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/reg_seq_alu.sv
// Combinational ALU for the sequencer: produces the commit value and carry/borrow.
module reg_seq_alu
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] y_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, ((op_i == OP_ADDI) ? imm_i : b_i)};
    // The extra top bit of the difference is the borrow (a < b).
    diff    = {1'b0, a_i} - {1'b0, b_i};
    y_o     = '0;
    carry_o = 1'b0;
    case (op_i)
      OP_ADD:  begin y_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
      OP_SUB:  begin y_o = diff[WIDTH-1:0]; carry_o = diff[WIDTH]; end
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_LDI:  y_o = imm_i;
      OP_MOV:  y_o = a_i;
      OP_ADDI: begin y_o = sum[WIDTH-1:0];  carry_o = sum[WIDTH];  end
      default: begin y_o = '0; carry_o = 1'b0; end
    endcase
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Sole driver of an always-writing register file: fetches operands through its
// combinational read port, computes one ALU op, and commits with a single write.
module reg_alu_sequencer
  import reg_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_src_a,
  input  logic [AW-1:0]    cmd_src_b,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic [AW-1:0]    rf_read,
  output logic [AW-1:0]    rf_write,
  output logic [WIDTH-1:0] rf_din,
  input  logic [WIDTH-1:0] rf_dout,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready is a pure function of state (high only in IDLE); command fields
  // are sampled only on that transfer edge, so a held cmd_valid is harmless.

  seq_state_e state_q, state_d;

  logic [OP_W-1:0]  op_q;
  logic [AW-1:0]    dst_q, src_a_q, src_b_q, ptr_q;
  logic [WIDTH-1:0] imm_q, a_q, b_q, result_q;
  logic             zero_q, carry_q, done_q;

  logic [AW-1:0]    rf_addr;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;

  reg_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i    (op_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .imm_i   (imm_q),
    .y_o     (alu_y),
    .carry_o (alu_carry)
  );

  // Every non-WR cycle rewrites the addressed register with its own value.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rf_addr   = ptr_q;
    rf_din    = rf_dout;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_op == OP_LDI) ? ST_WR : ST_RD_A;
      end
      ST_RD_A: begin
        rf_addr = src_a_q;
        state_d = op_reads_b(op_q) ? ST_RD_B : ST_WR;
      end
      ST_RD_B: begin
        rf_addr = src_b_q;
        state_d = ST_WR;
      end
      ST_WR: begin
        rf_addr = dst_q;
        rf_din  = alu_y;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rf_read  = rf_addr;
  assign rf_write = rf_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ptr_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ST_WR);
      if (state_q == ST_IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        dst_q   <= cmd_dst;
        src_a_q <= cmd_src_a;
        src_b_q <= cmd_src_b;
        imm_q   <= cmd_imm;
      end
      if (state_q == ST_RD_A) a_q <= rf_dout;
      if (state_q == ST_RD_B) b_q <= rf_dout;
      if (state_q == ST_WR) begin
        result_q <= alu_y;
        zero_q   <= (alu_y == '0);
        carry_q  <= alu_carry;
        ptr_q    <= dst_q;
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer with a behavioural 8x8 always-writing register file.
module tb_reg_alu_sequencer;
  import reg_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op, cmd_dst, cmd_src_a, cmd_src_b;
  logic [7:0] cmd_imm;
  logic [2:0] rf_read, rf_write;
  logic [7:0] rf_din, rf_dout;
  logic       done, zero, carry;
  logic [7:0] result;

  always #5 clock = ~clock;

  reg_alu_sequencer #(.WIDTH(8), .AW(3)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b), .cmd_imm(cmd_imm),
    .rf_read(rf_read), .rf_write(rf_write), .rf_din(rf_din), .rf_dout(rf_dout),
    .done(done), .result(result), .zero(zero), .carry(carry)
  );

  // register file: writes every edge, combinational read
  logic [7:0] rf_mem [8];
  always @(posedge clock) rf_mem[rf_write] <= rf_din;
  assign rf_dout = rf_mem[rf_read];

  typedef struct packed {
    logic [2:0]  dst;
    logic [7:0]  val;
    logic        z;
    logic        c;
    logic [3:0]  lat;
    logic [31:0] acc;
  } exp_t;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] sa;
    logic [2:0] sb;
    logic [7:0] imm;
    logic [7:0] val;
    logic       z;
    logic       c;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] exp_rf [8];
  logic [7:0] known = 8'h00;
  int         n_total = 0;
  int         n_bad = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  vec_t       tbl [21];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] imm, output logic [7:0] v, output logic z,
                                output logic c);
    int s;
    c = 1'b0;
    case (op)
      OP_ADD:  begin s = int'(a) + int'(b); v = 8'(s); c = (s > 255); end
      OP_SUB:  begin s = int'(a) - int'(b); if (s < 0) begin s += 256; c = 1'b1; end v = 8'(s); end
      OP_AND:  v = a & b;
      OP_OR:   v = a | b;
      OP_XOR:  v = a ^ b;
      OP_LDI:  v = imm;
      OP_MOV:  v = a;
      default: begin s = int'(a) + int'(imm); v = 8'(s); c = (s > 255); end
    endcase
    z = (v == 8'h00);
  endfunction

  function automatic logic [3:0] lat_of(input logic [2:0] op);
    if (op == OP_LDI) return 4'd1;
    if (op == OP_MOV || op == OP_ADDI) return 4'd2;
    return 4'd3;
  endfunction

  task automatic push_exp(input vec_t v, input bit use_model);
    exp_t e;
    logic [7:0] val;
    logic z, c;
    val = v.val; z = v.z; c = v.c;
    if (use_model) model(v.op, exp_rf[v.sa], exp_rf[v.sb], v.imm, val, z, c);
    e.dst = v.dst; e.val = val; e.z = z; e.c = c;
    e.lat = lat_of(v.op); e.acc = 32'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic drive_fields(input vec_t v);
    cmd_op = v.op; cmd_dst = v.dst; cmd_src_a = v.sa; cmd_src_b = v.sb; cmd_imm = v.imm;
  endtask

  task automatic scramble_fields();
    cmd_op = 3'($urandom_range(0, 7)); cmd_dst = 3'($urandom_range(0, 7));
    cmd_src_a = 3'($urandom_range(0, 7)); cmd_src_b = 3'($urandom_range(0, 7));
    cmd_imm = 8'($urandom_range(0, 255));
  endtask

  // Waits (bounded) at negedges for ready; returns 1 once the accept edge has passed.
  task automatic wait_accept(output bit ok);
    int waited;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    ok = (cmd_ready === 1'b1);
    if (!ok) begin
      n_total++; n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
    end else begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic issue(input vec_t v, input bit use_model);
    bit ok;
    @(negedge clock);
    cmd_valid = 1'b1;
    drive_fields(v);
    wait_accept(ok);
    if (ok) push_exp(v, use_model);
    cmd_valid = 1'b0;
    scramble_fields();
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_total++; n_bad++;
      $display("FAIL drain_timeout: %0d commits pending, want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  // Scoreboard: pop on done, then confirm every known register matches the model.
  always @(negedge clock) begin
    if (mon_en) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 32'(result), 32'(mon_e.val));
          check("zero", 32'(zero), 32'(mon_e.z));
          check("carry", 32'(carry), 32'(mon_e.c));
          check("rf_dout_after_commit", 32'(rf_dout), 32'(mon_e.val));
          check("latency", 32'(cyc) - mon_e.acc, 32'(mon_e.lat));
          exp_rf[mon_e.dst] = mon_e.val;
          known[mon_e.dst] = 1'b1;
        end
      end
      if (known != 8'h00) begin
        n_total++;
        for (int i = 0; i < 8; i++) begin
          if (known[i] && rf_mem[i] !== exp_rf[i]) begin
            n_bad++;
            $display("FAIL rf_state: r%0d got %0h want %0h (cycle %0d)", i, rf_mem[i], exp_rf[i], cyc);
            break;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int prev;
    vec_t v;

    tbl[0]  = '{OP_LDI,  3'd0, 3'd0, 3'd0, 8'h11, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{OP_LDI,  3'd1, 3'd4, 3'd6, 8'hC8, 8'hC8, 1'b0, 1'b0};
    tbl[2]  = '{OP_LDI,  3'd2, 3'd0, 3'd0, 8'h64, 8'h64, 1'b0, 1'b0};
    tbl[3]  = '{OP_LDI,  3'd4, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{OP_LDI,  3'd5, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0, 1'b0};
    tbl[5]  = '{OP_LDI,  3'd6, 3'd0, 3'd0, 8'h66, 8'h66, 1'b0, 1'b0};
    tbl[6]  = '{OP_LDI,  3'd7, 3'd0, 3'd0, 8'h77, 8'h77, 1'b0, 1'b0};
    tbl[7]  = '{OP_LDI,  3'd3, 3'd0, 3'd0, 8'h2A, 8'h2A, 1'b0, 1'b0};
    tbl[8]  = '{OP_ADD,  3'd4, 3'd1, 3'd2, 8'h00, 8'h2C, 1'b0, 1'b1};
    tbl[9]  = '{OP_SUB,  3'd5, 3'd2, 3'd1, 8'h00, 8'h9C, 1'b0, 1'b1};
    tbl[10] = '{OP_SUB,  3'd5, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{OP_AND,  3'd0, 3'd1, 3'd2, 8'hFF, 8'h40, 1'b0, 1'b0};
    tbl[12] = '{OP_OR,   3'd6, 3'd1, 3'd2, 8'h00, 8'hEC, 1'b0, 1'b0};
    tbl[13] = '{OP_XOR,  3'd7, 3'd1, 3'd2, 8'h00, 8'hAC, 1'b0, 1'b0};
    tbl[14] = '{OP_XOR,  3'd3, 3'd3, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[15] = '{OP_LDI,  3'd1, 3'd0, 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    tbl[16] = '{OP_ADDI, 3'd1, 3'd1, 3'd6, 8'h01, 8'h00, 1'b1, 1'b1};
    tbl[17] = '{OP_MOV,  3'd7, 3'd1, 3'd5, 8'h99, 8'h00, 1'b1, 1'b0};
    tbl[18] = '{OP_ADD,  3'd2, 3'd2, 3'd2, 8'h00, 8'hC8, 1'b0, 1'b0};
    tbl[19] = '{OP_ADDI, 3'd0, 3'd0, 3'd3, 8'hC0, 8'h00, 1'b1, 1'b1};
    tbl[20] = '{OP_SUB,  3'd6, 3'd6, 3'd4, 8'h00, 8'hC0, 1'b0, 1'b0};

    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_dst = 3'd0; cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_imm = 8'h00;

    // reset state
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rf_read", 32'(rf_read), 32'd0);
    check("rst_rf_write", 32'(rf_write), 32'd0);
    check("rst_rf_din_refresh", 32'(rf_din), 32'(rf_mem[0]));
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    reset = 1'b1;
    mon_en = 1'b1;

    // directed table
    for (int i = 0; i < 21; i++) issue(tbl[i], 1'b0);
    drain();

    // back-to-back LDI with cmd_valid held high throughout
    prev = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    v = '{OP_LDI, 3'($urandom_range(0, 7)), 3'd0, 3'd0, 8'($urandom_range(0, 255)), 8'h00, 1'b0, 1'b0};
    drive_fields(v);
    for (int k = 0; k < 8; k++) begin
      wait_accept(ok);
      if (!ok) break;
      push_exp(v, 1'b1);
      if (k > 0) check("b2b_spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
      v.dst = 3'($urandom_range(0, 7));
      v.imm = 8'($urandom_range(0, 255));
      v.sa  = 3'($urandom_range(0, 7));
      drive_fields(v);
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    drain();

    // random commands with idle gaps; valid is held while the sequencer is busy
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      v.op  = 3'($urandom_range(0, 7));
      v.dst = 3'($urandom_range(0, 7));
      v.sa  = 3'($urandom_range(0, 7));
      v.sb  = 3'($urandom_range(0, 7));
      v.imm = 8'($urandom_range(0, 255));
      issue(v, 1'b1);
    end
    drain();

    // reset pulse while an ADD to r6 is in RD_B
    @(negedge clock);
    cmd_valid = 1'b1;
    v = '{OP_ADD, 3'd6, 3'd1, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0};
    drive_fields(v);
    wait_accept(ok);
    cmd_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rf_write", 32'(rf_write), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_rf_read", 32'(rf_read), 32'd0);
    repeat (8) @(negedge clock);

    // recovery after the abandoned command
    v = '{OP_ADDI, 3'd6, 3'd6, 3'd0, 8'h03, 8'h00, 1'b0, 1'b0};
    issue(v, 1'b1);
    drain();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
